serial_word_loader: RTL

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

---
 rtl/serial_word_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: shifts MSB-first bits into a word and strobes ld for one cycle.
// Optional even-parity check compiled in by defining SERIAL_PARITY_EN.
module serial_word_loader #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sin,
    input  logic            sin_valid,
    output logic            ready,
    output logic            busy,
    output logic [size-1:0] data,
    output logic            ld,
    output logic            err
);
    localparam int CW = $clog2(size) + 1;

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, LOAD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd3} state_t;
`endif

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [size-1:0] r_data;
    logic            w_last;

    assign w_last = (r_cnt == CW'(size - 1));

`ifdef SERIAL_PARITY_EN
    logic r_par;
    logic r_err;
    logic w_par_bad;

    assign w_par_bad = r_par ^ sin;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = SHIFT;
            SHIFT: if (sin_valid && w_last) begin
`ifdef SERIAL_PARITY_EN
                w_next = PARITY;
`else
                w_next = LOAD;
`endif
            end
`ifdef SERIAL_PARITY_EN
            // A bad parity bit returns straight to IDLE; err is raised from r_err instead of LOAD.
            PARITY: if (sin_valid) w_next = w_par_bad ? IDLE : LOAD;
`endif
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The word is deliberately not cleared on start, only overwritten bit by bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT && sin_valid) begin
            r_data <= {r_data[size-2:0], sin};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == PARITY) && sin_valid && w_par_bad;
            if (r_state == IDLE && start)           r_par <= 1'b0;
            else if (r_state == SHIFT && sin_valid) r_par <= r_par ^ sin;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign ready = (r_state == IDLE);
    assign busy  = (r_state != IDLE);
    assign ld    = (r_state == LOAD);
    assign data  = r_data;
endmodule
